// File: rtl/io_tx_axi_writer.sv
// io_tx_axi_writer
// Buffers 32-bit words from a core in a small FIFO and forwards each one to a
// memory-mapped peripheral over AXI4-Lite. Before every write the peripheral
// status register is polled until its TX-full bit reads clear.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the FIFO to hold at least one word
// POLL_AR | status read address presented
// POLL_R  | waiting for status read data
// WR_AW_W | write address and data presented; each drops on its own ready
// WR_B    | waiting for the write response; FIFO head popped on bvalid

module io_tx_axi_writer #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [31:0] STAT_ADDR  = 32'h0000_0008,
    parameter logic [31:0] TX_ADDR    = 32'h0000_0004,
    parameter int unsigned TXFULL_BIT = 3
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        out_req,
    input  logic [31:0] out_data,
    output logic        out_busy,

    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,

    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,

    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,

    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,

    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,

    output logic        overflow,
    output logic        axi_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POLL_AR = 3'd1,
        POLL_R  = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4
    } state_e;

    state_e        state_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          bready_q;
    logic          overflow_q;
    logic          axi_err_q;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          status_busy;
    logic          aw_done;
    logic          w_done;
    logic          err_event;
    logic          unused_rdata;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = out_req && !full;
    // The head stays in place through the whole write; it leaves only once
    // the response has been accepted, whatever its code.
    assign pop    = (state_q == WR_B) && bready_q && axi_bvalid;

    assign status_busy = axi_rdata[TXFULL_BIT] || (axi_rresp != 2'b00);
    assign aw_done     = !awvalid_q || axi_awready;
    assign w_done      = !wvalid_q  || axi_wready;
    assign err_event   = (axi_rvalid && rready_q && (axi_rresp != 2'b00)) ||
                         (axi_bvalid && bready_q && (axi_bresp != 2'b00));

    // Only the TX-full bit of the status word matters here.
    assign unused_rdata = ^axi_rdata;

    // Next-state pointer and occupancy; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
            axi_err_q  <= 1'b0;
        end else begin
            if (out_req && full) begin
                overflow_q <= 1'b1;
            end
            if (err_event) begin
                axi_err_q <= 1'b1;
            end
        end
    end

    // Sequencer: poll status, then write the head word; handshake outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q   <= POLL_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                POLL_AR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (status_busy) begin
                            // Peripheral full or read failed: ask again.
                            arvalid_q <= 1'b1;
                            state_q   <= POLL_AR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_AW_W;
                        end
                    end
                end
                WR_AW_W: begin
                    if (awvalid_q && axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi_bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_busy    = full;
    assign overflow    = overflow_q;
    assign axi_err     = axi_err_q;

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = STAT_ADDR;
    assign axi_arprot  = 3'b000;
    assign axi_rready  = rready_q;

    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = TX_ADDR;
    assign axi_awprot  = 3'b000;

    // Data bus is quiet whenever no write beat is offered.
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wvalid_q ? mem_q[rd_ptr_q] : 32'h0000_0000;
    assign axi_wstrb   = 4'b1111;

    assign axi_bready  = bready_q;

endmodule

// File: tb/tb_io_tx_axi_writer.sv
// Directed bench for io_tx_axi_writer with a behavioural AXI4-Lite slave.
module tb_io_tx_axi_writer;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        out_req = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_busy;
    logic        axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
    logic        axi_arready = 1'b0, axi_rvalid = 1'b0;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr;
    logic [31:0] axi_rdata = '0;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp = '0, axi_rresp = '0;
    logic        overflow, axi_err;

    always #5 clk = ~clk;

    io_tx_axi_writer dut (
        .clk(clk), .rstn(rstn),
        .out_req(out_req), .out_data(out_data), .out_busy(out_busy),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .overflow(overflow), .axi_err(axi_err)
    );

    // slave configuration, written only by the stimulus process
    int cfg_busy = 0, cfg_rerr = 0, cfg_berr = 0, cfg_aw_dly = 0, cfg_w_dly = 0;
    logic ar_stall = 1'b0, b_stall = 1'b0;

    // slave state and observations, written only by the slave process
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, viol = 0;
    int busy_left = 0, rerr_left = 0, berr_left = 0, aw_wait = 0, w_wait = 0;
    logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    logic aw_seen = 0, w_seen = 0, b_pend = 0;
    logic p_ar = 0, p_aw = 0, p_w = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] wlog[$];

    // Slave: acts on the falling edge, so everything it drives is stable at the rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
            axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            aw_seen = 0; w_seen = 0; b_pend = 0; p_ar = 0; p_aw = 0; p_w = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0;
            busy_left = cfg_busy; rerr_left = cfg_rerr; berr_left = cfg_berr;
            aw_wait = cfg_aw_dly; w_wait = cfg_w_dly;
            wlog.delete();
        end else begin
            if (p_ar && !axi_arvalid) viol++;
            if (p_aw && !axi_awvalid) viol++;
            if (p_w  && !axi_wvalid)  viol++;
            if (r_hs) axi_rvalid = 0;
            if (ar_hs) begin
                ar_cnt++;
                axi_rvalid = 1;
                if (busy_left > 0) begin
                    axi_rdata = 32'h0000_0008; axi_rresp = 2'b00; busy_left--;
                end else if (rerr_left > 0) begin
                    axi_rdata = 32'h0000_0000; axi_rresp = 2'b10; rerr_left--;
                end else begin
                    axi_rdata = 32'hFFFF_FFF7; axi_rresp = 2'b00;
                end
            end
            if (aw_hs) begin aw_cnt++; aw_seen = 1; aw_wait = cfg_aw_dly; end
            if (w_hs)  begin w_cnt++;  w_seen = 1;  w_wait = cfg_w_dly;  end
            if (b_hs)  begin b_cnt++;  axi_bvalid = 0; end
            if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
            if (b_pend && !b_stall && !axi_bvalid) begin
                axi_bvalid = 1;
                if (berr_left > 0) begin axi_bresp = 2'b10; berr_left--; end
                else axi_bresp = 2'b00;
                b_pend = 0;
            end
            axi_arready = axi_arvalid && !ar_stall;
            if (axi_awvalid && aw_wait > 0) begin aw_wait--; axi_awready = 0; end
            else axi_awready = axi_awvalid;
            if (axi_wvalid && w_wait > 0) begin w_wait--; axi_wready = 0; end
            else axi_wready = axi_wvalid;
            ar_hs = axi_arvalid && axi_arready;
            r_hs  = axi_rvalid && axi_rready;
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            b_hs  = axi_bvalid && axi_bready;
            if (ar_hs) last_araddr = axi_araddr;
            if (aw_hs) last_awaddr = axi_awaddr;
            if (w_hs) begin wlog.push_back(axi_wdata); last_wstrb = axi_wstrb; end
            p_ar = axi_arvalid && !axi_arready;
            p_aw = axi_awvalid && !axi_awready;
            p_w  = axi_wvalid && !axi_wready;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #3;
    endtask

    task automatic wait_b(input string name, input int target, input int budget);
        int n = 0;
        while (b_cnt < target && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        check(name, b_cnt, target);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, axi_arvalid, 0);
        check({tag, "_rready"},  axi_rready, 0);
        check({tag, "_awvalid"}, axi_awvalid, 0);
        check({tag, "_wvalid"},  axi_wvalid, 0);
        check({tag, "_bready"},  axi_bready, 0);
        check({tag, "_busy"},    out_busy, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_err"},     axi_err, 0);
    endtask

    function automatic logic [31:0] wlog_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 32'hxxxx_xxxx;
    endfunction

    typedef struct {
        logic [31:0] data;
        int   busy_polls;
        int   rerr_polls;
        int   aw_dly;
        int   w_dly;
        int   berr;
        int   exp_ar;
        logic exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        //                data           busy rerr awd wd berr ar err
        vecs[0] = '{32'h0000_0041,   0,   0,   0,  0,  0,  1, 1'b0};
        vecs[1] = '{32'hDEAD_BEEF,   2,   0,   0,  0,  0,  3, 1'b0};
        vecs[2] = '{32'h1234_5678,   0,   0,   0,  3,  0,  1, 1'b0};
        vecs[3] = '{32'hA5A5_A5A5,   0,   0,   3,  0,  0,  1, 1'b0};
        vecs[4] = '{32'h0000_0000,   0,   0,   0,  0,  1,  1, 1'b1};
        vecs[5] = '{32'hFFFF_0000,   0,   1,   0,  0,  0,  2, 1'b1};

        // reset values, asserted asynchronously
        #3 rstn = 1'b0;
        #1 check_quiet("rst_async");
        check("rst_awprot", axi_awprot, 0);
        check("rst_arprot", axi_arprot, 0);
        apply_reset();

        // first-word latency: arvalid appears two cycles after the push cycle
        @(negedge clk); out_req = 1; out_data = 32'h0000_0041;
        @(negedge clk); out_req = 0;
        check("lat_arvalid_n1", axi_arvalid, 0);
        @(negedge clk);
        check("lat_arvalid_n2", axi_arvalid, 1);
        wait_b("lat_b", 1, 60);

        // single-word transactions under several slave behaviours
        for (int i = 0; i < 6; i++) begin
            cfg_busy = vecs[i].busy_polls; cfg_rerr = vecs[i].rerr_polls;
            cfg_aw_dly = vecs[i].aw_dly; cfg_w_dly = vecs[i].w_dly; cfg_berr = vecs[i].berr;
            apply_reset();
            @(negedge clk); out_req = 1; out_data = vecs[i].data;
            @(negedge clk); out_req = 0;
            wait_b($sformatf("v%0d_b", i), 1, 120);
            repeat (8) @(posedge clk);
            #3;
            check($sformatf("v%0d_ar_cnt", i), ar_cnt, vecs[i].exp_ar);
            check($sformatf("v%0d_aw_cnt", i), aw_cnt, 1);
            check($sformatf("v%0d_w_cnt", i), w_cnt, 1);
            check($sformatf("v%0d_b_cnt", i), b_cnt, 1);
            check($sformatf("v%0d_wdata", i), wlog_at(0), vecs[i].data);
            check($sformatf("v%0d_awaddr", i), last_awaddr, 32'h4);
            check($sformatf("v%0d_araddr", i), last_araddr, 32'h8);
            check($sformatf("v%0d_wstrb", i), last_wstrb, 4'hF);
            check($sformatf("v%0d_err", i), axi_err, vecs[i].exp_err);
            check($sformatf("v%0d_viol", i), viol, 0);
        end
        cfg_busy = 0; cfg_rerr = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_berr = 0;

        // fill past capacity while the slave stalls status reads
        ar_stall = 1;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); out_req = 1; out_data = 32'h100 + i;
            check($sformatf("fill%0d_busy", i), out_busy, (i == 16) ? 1 : 0);
        end
        check("fill_ovf_before", overflow, 0);
        @(negedge clk); out_req = 0;
        check("fill_ovf_after", overflow, 1);
        check("fill_busy_held", out_busy, 1);
        #1 ar_stall = 0;
        wait_b("fill_b16", 16, 600);
        repeat (20) @(posedge clk);
        #3;
        check("fill_no17th", b_cnt, 16);
        check("fill_ar_cnt", ar_cnt, 16);
        check("fill_busy_drain", out_busy, 0);
        check("fill_ovf_sticky", overflow, 1);
        for (int i = 0; i < 16; i++)
            check($sformatf("fill_order%0d", i), wlog_at(i), 32'h100 + i);

        // error response on the first write does not block the next one
        cfg_berr = 1;
        apply_reset();
        @(negedge clk); out_req = 1; out_data = 32'hC001;
        @(negedge clk); out_data = 32'hC002;
        @(negedge clk); out_req = 0;
        wait_b("berr_b2", 2, 200);
        check("berr_err", axi_err, 1);
        check("berr_w0", wlog_at(0), 32'hC001);
        check("berr_w1", wlog_at(1), 32'hC002);
        check("berr_ar_cnt", ar_cnt, 2);
        check("berr_viol", viol, 0);
        cfg_berr = 0;

        // reset while waiting for a write response with words queued
        b_stall = 1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); out_req = 1; out_data = 32'h500 + i;
        end
        @(negedge clk); out_req = 0;
        for (int n = 0; n < 100 && !(aw_cnt >= 1 && w_cnt >= 1); n++) begin
            @(posedge clk); #3;
        end
        repeat (2) @(posedge clk);
        #3;
        check("wrb_bready", axi_bready, 1);
        check("wrb_aw_cnt", aw_cnt, 1);
        #1 rstn = 1'b0;
        #1 check_quiet("wrb_rst");
        b_stall = 0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        check("wrb_idle_ar", ar_cnt, 0);
        check("wrb_idle_aw", aw_cnt, 0);
        check("wrb_idle_arvalid", axi_arvalid, 0);
        @(negedge clk); out_req = 1; out_data = 32'h600;
        @(negedge clk); out_req = 0;
        wait_b("wrb_new_b", 1, 100);
        repeat (20) @(posedge clk);
        #3;
        check("wrb_new_data", wlog_at(0), 32'h600);
        check("wrb_new_only", b_cnt, 1);
        check("wrb_new_ar", ar_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/io_tx_axi_writer.md
IO_TX_AXI_WRITER -- requirements
Module: io_tx_axi_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STAT_ADDR, default 32'h0000_0008, AXI address of the peripheral status register.
REQ-003 SHALL have parameter TX_ADDR, default 32'h0000_0004, AXI address of the peripheral transmit register.
REQ-004 SHALL have parameter TXFULL_BIT, default 3, status bit meaning "peripheral TX full".
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock (all state on rising edge).
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 out_req  in  1  core output request, one word per asserted cycle.
REQ-008 out_data  in  32  word to transmit.
REQ-009 out_busy  out  1  FIFO full; core must not assert out_req.
REQ-010 axi_awvalid/axi_awready/axi_awaddr[31:0]/axi_awprot[2:0]  out/in/out/out  AXI4-Lite write address.
REQ-011 axi_wvalid/axi_wready/axi_wdata[31:0]/axi_wstrb[3:0]  out/in/out/out  write data.
REQ-012 axi_bvalid/axi_bready/axi_bresp[1:0]  in/out/in  write response.
REQ-013 axi_arvalid/axi_arready/axi_araddr[31:0]/axi_arprot[2:0]  out/in/out/out  read address.
REQ-014 axi_rvalid/axi_rready/axi_rdata[31:0]/axi_rresp[1:0]  in/out/in/in  read data.
REQ-015 overflow  out  1  sticky: out_req received while full.
REQ-016 axi_err  out  1  sticky: any nonzero bresp or rresp.

Function
REQ-017 SHALL hold words in a DEPTH-entry FIFO; push when out_req && !full; out_busy = (count == DEPTH), combinational from count.
REQ-018 SHALL drop out_req while full and set overflow; FIFO contents unchanged.
REQ-019 SHALL support push and pop in the same cycle; count unchanged, data order preserved; wrap-around of pointers modulo DEPTH.
REQ-020 FSM states: IDLE, POLL_AR, POLL_R, WR_AW_W, WR_B.
REQ-021 IDLE: FIFO non-empty -> POLL_AR next cycle; else stay.
REQ-022 POLL_AR: axi_arvalid=1, axi_araddr=STAT_ADDR; on arready -> POLL_R.
REQ-023 POLL_R: axi_rready=1; on rvalid: rdata[TXFULL_BIT]=1 or rresp!=0 -> POLL_AR (re-poll); else -> WR_AW_W.
REQ-024 WR_AW_W: axi_awvalid and axi_wvalid asserted together, awaddr=TX_ADDR, wdata=FIFO head, wstrb=4'b1111; each valid drops independently after its own ready; -> WR_B when both handshakes complete (same or different cycles).
REQ-025 WR_B: axi_bready=1; on bvalid pop FIFO head (regardless of bresp) -> IDLE.
REQ-026 SHALL set axi_err on rvalid&&rready with rresp!=0 or bvalid&&bready with bresp!=0.
REQ-027 axi_awprot=axi_arprot=3'b000 always; valids never withdrawn before ready.
REQ-028 FIFO head SHALL not change between WR_AW_W entry and pop.
REQ-029 Minimum word latency: push cycle N, arvalid N+2 (registered count/empty), assuming zero-wait slave.

Reset
REQ-030 On rstn=0, immediately: state IDLE, FIFO empty, all valids/readies 0, out_busy 0, overflow 0, axi_err 0.
REQ-031 Reset mid-transaction SHALL abandon it; buffered words discarded; no AXI signal held after reset.
REQ-032 Sticky flags clear only by reset.

Verification
REQ-033 Single word 32'h0000_0041, zero-wait slave, status 0 -> one AR to 0x8, one AW/W to 0x4 with wdata 0x41, FIFO empty after B.
REQ-034 Status returns bit3=1 twice then 0 -> exactly three AR transactions before the single write.
REQ-035 Push 17 words back-to-back with slave stalled -> out_busy high after 16th, 17th dropped, overflow=1, first 16 words written in order.
REQ-036 awready 3 cycles before wready, then reverse -> each valid deasserts only after its ready; exactly one B wait per word.
REQ-037 bresp=2'b10 on first write -> axi_err=1, word still popped, next word proceeds normally.
REQ-038 rstn low during WR_B with 5 words queued -> all outputs at reset values asynchronously; after release no AXI activity until new out_req.
